// File: rtl/anu_pkg.sv
// Shared definitions for the anu load/store unit: size encodings, FSM states
// and the byte-enable generator.
package anu_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_B    = 2'b01;
  localparam logic [1:0] SZ_H    = 2'b10;
  localparam logic [1:0] SZ_W    = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_RESP = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_t;

  // Byte enables across two adjacent words; the upper nibble is only non-zero
  // for accesses that straddle a word boundary.
  function automatic logic [7:0] size_strb(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/anu_lsu_align.sv
// Combinational lane steering for anu_lsu: store data/strobes per beat and
// load extraction with sign/zero extension.
module anu_lsu_align
  import anu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  off,
  input  logic        split,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [3:0]  strb_lo,
  output logic [3:0]  strb_hi,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] rdata_ext
);

  logic [7:0]  strb8;
  logic [31:0] wrep;
  logic [31:0] rsh;

  always_comb begin
    strb8   = size_strb(size, off);
    strb_lo = strb8[3:0];
    strb_hi = strb8[7:4];

    case (size)
      SZ_B:    wrep = {4{wdata[7:0]}};
      SZ_H:    wrep = {2{wdata[15:0]}};
      default: wrep = wdata;
    endcase

    // A straddling store needs the data placed at its true byte offset.
    if (split) begin
      {wdata_hi, wdata_lo} = {32'h0, wdata} << {off, 3'b000};
    end else begin
      wdata_lo = wrep;
      wdata_hi = 32'h0;
    end

    rsh = 32'({rdata_hi, rdata_lo} >> {off, 3'b000});
    case (size)
      SZ_B:    rdata_ext = {{24{sgn & rsh[7]}}, rsh[7:0]};
      SZ_H:    rdata_ext = {{16{sgn & rsh[15]}}, rsh[15:0]};
      default: rdata_ext = rsh;
    endcase
  end

endmodule

// File: rtl/anu_lsu.sv
// Multi-cycle load/store unit between the anu core and a handshaked memory bus.
// Define ANU_LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two beats.
//
// state | meaning
// IDLE  | waiting for a core request
// REQ   | mem_req high, holding the beat until mem_gnt
// RESP  | waiting for mem_rvalid of the granted beat
// DONE  | one-cycle rsp_valid, request not re-accepted
module anu_lsu
  import anu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

`ifdef ANU_LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT != 0) ? TIMEOUT - 1 : 0);

  lsu_state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q, size_q;
  logic              we_q, sgn_q, split_q, beat_q, err_q;
  logic [31:0]       wdata_q, rlo_q, rhi_q;
  logic [TO_W-1:0]   to_cnt_q;

  logic        req_go, req_mis, to_hit;
  logic [3:0]  strb_lo, strb_hi;
  logic [31:0] wdata_lo, wdata_hi, rdata_ext;

  assign req_go  = req_valid && (req_size != SZ_NONE);
  assign req_mis = ((req_size == SZ_H) && req_addr[0]) ||
                   ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
  assign to_hit  = TO_EN && (to_cnt_q == TO_LAST);

  anu_lsu_align u_align (
    .size      (size_q),
    .sgn       (sgn_q),
    .off       (off_q),
    .split     (split_q),
    .wdata     (wdata_q),
    .rdata_lo  (rlo_q),
    .rdata_hi  (rhi_q),
    .strb_lo   (strb_lo),
    .strb_hi   (strb_hi),
    .wdata_lo  (wdata_lo),
    .wdata_hi  (wdata_hi),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LSU_IDLE: if (req_go) state_d = (req_mis && !SPLIT_EN) ? LSU_DONE : LSU_REQ;
      LSU_REQ:  if (mem_gnt) state_d = LSU_RESP;
                else if (to_hit) state_d = LSU_DONE;
      LSU_RESP: if (mem_rvalid) state_d = (split_q && !beat_q) ? LSU_REQ : LSU_DONE;
                else if (to_hit) state_d = LSU_DONE;
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      off_q    <= 2'b00;
      size_q   <= SZ_NONE;
      we_q     <= 1'b0;
      sgn_q    <= 1'b0;
      split_q  <= 1'b0;
      beat_q   <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= 32'h0;
      rlo_q    <= 32'h0;
      rhi_q    <= 32'h0;
      to_cnt_q <= '0;
    end else begin
      case (state_q)
        LSU_IDLE: if (req_go) begin
          addr_q   <= {req_addr[ADDR_W-1:2], 2'b00};
          off_q    <= req_addr[1:0];
          size_q   <= req_size;
          we_q     <= req_we;
          sgn_q    <= req_signed;
          wdata_q  <= req_wdata;
          split_q  <= req_mis && SPLIT_EN;
          err_q    <= req_mis && !SPLIT_EN;
          beat_q   <= 1'b0;
          rlo_q    <= 32'h0;
          rhi_q    <= 32'h0;
          to_cnt_q <= '0;
        end
        LSU_REQ: begin
          if (mem_gnt) to_cnt_q <= '0;
          else if (to_hit) begin
            err_q    <= 1'b1;
            to_cnt_q <= '0;
          end else to_cnt_q <= to_cnt_q + TO_W'(1);
        end
        LSU_RESP: begin
          if (mem_rvalid) begin
            to_cnt_q <= '0;
            if (beat_q) rhi_q <= mem_rdata;
            else        rlo_q <= mem_rdata;
            if (split_q && !beat_q) begin
              beat_q <= 1'b1;
              addr_q <= addr_q + ADDR_W'(4);
            end
          end else if (to_hit) begin
            err_q    <= 1'b1;
            to_cnt_q <= '0;
          end else to_cnt_q <= to_cnt_q + TO_W'(1);
        end
        default: to_cnt_q <= '0;
      endcase
    end
  end

  // stall is gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    stall     = rst_n && (((state_q == LSU_IDLE) && req_go) ||
                          (state_q == LSU_REQ) || (state_q == LSU_RESP));
    mem_req   = (state_q == LSU_REQ);
    mem_we    = mem_req && we_q;
    mem_addr  = mem_req ? addr_q : '0;
    mem_wstrb = mem_req ? (beat_q ? strb_hi : strb_lo) : 4'h0;
    mem_wdata = mem_we ? (beat_q ? wdata_hi : wdata_lo) : 32'h0;
    rsp_valid = (state_q == LSU_DONE);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !err_q && !we_q) ? rdata_ext : 32'h0;
  end

endmodule

// File: tb/tb_anu_lsu.sv
// Self-checking bench for anu_lsu: directed cases plus randomized accesses
// compared against a byte-array memory model.
module tb_anu_lsu;

`ifdef ANU_LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  anu_lsu #(.ADDR_W(32), .TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] bus_mem [0:15];
  logic [7:0]  ref_mem [0:63];

  int          r_done_cyc, r_stall, r_req_cyc;
  logic        r_err, r_stable, r_mreq_after, r_extra;
  logic [31:0] r_rdata, r_addr0, r_wdata0;
  logic [3:0]  r_strb0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one request, plays the bus with gd wait cycles before each grant and
  // rd wait cycles before each rvalid, and records what the DUT did.
  task automatic run_access(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int gd, input int rd);
    int cyc, gw, rw, pidx;
    bit pend, done, seen;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_strb;
    logic        h_we;
    r_done_cyc = -1; r_err = 1'b0; r_rdata = 32'h0; r_stall = 0; r_req_cyc = 0;
    r_stable = 1'b1; r_mreq_after = 1'b0; r_addr0 = 32'h0; r_wdata0 = 32'h0; r_strb0 = 4'h0;
    h_addr = 32'h0; h_wdata = 32'h0; h_strb = 4'h0; h_we = 1'b0;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    cyc = 0; gw = 0; rw = 0; pidx = 0; pend = 0; done = 0; seen = 0;
    while (!done && cyc < 60) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      if (pend) begin
        if (rw >= rd) begin
          mem_rvalid = 1'b1; mem_rdata = bus_mem[pidx]; pend = 0;
        end else rw++;
      end
      if (mem_req) begin
        if (!seen) begin
          seen = 1; r_addr0 = mem_addr; r_strb0 = mem_wstrb; r_wdata0 = mem_wdata;
        end
        if (gw == 0) begin
          h_addr = mem_addr; h_strb = mem_wstrb; h_wdata = mem_wdata; h_we = mem_we;
        end else if (mem_addr !== h_addr || mem_wstrb !== h_strb ||
                     mem_wdata !== h_wdata || mem_we !== h_we) r_stable = 1'b0;
        if (gw >= gd) begin
          mem_gnt = 1'b1; pend = 1; rw = 0; gw = 0; pidx = int'(mem_addr[5:2]);
          if (mem_we)
            for (int k = 0; k < 4; k++)
              if (mem_wstrb[k]) bus_mem[pidx][8*k +: 8] = mem_wdata[8*k +: 8];
        end else gw++;
      end
      @(negedge clk);
      if (stall) r_stall++;
      if (mem_req) r_req_cyc++;
      if (rsp_valid) begin
        r_done_cyc = cyc; r_err = rsp_err; r_rdata = rsp_rdata; r_mreq_after = mem_req;
        done = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    r_extra = rsp_valid;
    @(posedge clk); #1;
  endtask

  // Reference: byte-addressed memory and per-beat latency arithmetic.
  task automatic ref_access(input logic we, input logic [1:0] size, input logic sgn,
                            input int a, input logic [31:0] wd, input int gd, input int rd,
                            output int lat, output logic err, output logic [31:0] rdat);
    int n, beats;
    bit mis;
    logic [31:0] v;
    n = (size == 2'd1) ? 1 : (size == 2'd2) ? 2 : 4;
    mis = (a % n) != 0;
    lat = 1; err = 1'b0; rdat = 32'h0;
    if (mis && !SPLIT) begin
      err = 1'b1;
      return;
    end
    beats = mis ? 2 : 1;
    for (int b = 0; b < beats && !err; b++) begin
      if (gd >= 4) begin lat += 4; err = 1'b1; end
      else begin
        lat += gd + 1;
        if (rd >= 4) begin lat += 4; err = 1'b1; end
        else lat += rd + 1;
      end
    end
    if (err) return;
    if (we) begin
      for (int k = 0; k < n; k++) ref_mem[a + k] = wd[8*k +: 8];
    end else begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
      if (n < 4 && sgn && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rdat = v;
    end
  endtask

  task automatic init_mem();
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      bus_mem[i] = w;
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
    end
  endtask

  initial begin
    int lat, gd, rd, a, extra;
    logic err, we, sgn;
    logic [1:0]  sz;
    logic [31:0] rdat, wd;

    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    init_mem();
    #2;
    check_val("rst_stall", 32'(stall), 32'h0);
    check_val("rst_mem_req", 32'(mem_req), 32'h0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_val("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // store byte, zero-wait bus
    run_access(1'b1, 2'b01, 1'b0, 32'h1003, 32'h1234_56A5, 0, 0);
    check_val("sb_addr", r_addr0, 32'h1000);
    check_val("sb_strb", 32'(r_strb0), 32'h8);
    check_val("sb_wdata", r_wdata0, 32'hA5A5_A5A5);
    check_val("sb_lat", 32'(r_done_cyc), 32'd3);
    check_val("sb_stall", 32'(r_stall), 32'd3);
    check_val("sb_err", 32'(r_err), 32'h0);
    check_val("sb_rdata", r_rdata, 32'h0);
    check_val("sb_extra", 32'(r_extra), 32'h0);

    // signed half load with three grant wait cycles
    bus_mem[0] = 32'h8001_1234;
    run_access(1'b0, 2'b10, 1'b1, 32'h2002, 32'h0, 3, 0);
    check_val("lh_rdata", r_rdata, 32'hFFFF_8001);
    check_val("lh_stable", 32'(r_stable), 32'h1);
    check_val("lh_lat", 32'(r_done_cyc), 32'd6);
    check_val("lh_strb", 32'(r_strb0), 32'hC);

    // misaligned word load
    bus_mem[0] = 32'h4433_2211;
    bus_mem[1] = 32'h8877_6655;
    run_access(1'b0, 2'b11, 1'b0, 32'h3001, 32'h0, 0, 0);
    if (SPLIT) begin
      check_val("mis_rdata", r_rdata, 32'h5544_3322);
      check_val("mis_err", 32'(r_err), 32'h0);
      check_val("mis_req_cyc", 32'(r_req_cyc), 32'd2);
      check_val("mis_lat", 32'(r_done_cyc), 32'd5);
    end else begin
      check_val("mis_err", 32'(r_err), 32'h1);
      check_val("mis_req_cyc", 32'(r_req_cyc), 32'd0);
      check_val("mis_lat", 32'(r_done_cyc), 32'd1);
      check_val("mis_rdata", r_rdata, 32'h0);
    end

    // grant never arrives
    run_access(1'b0, 2'b11, 1'b0, 32'h1000, 32'h0, 99, 0);
    check_val("to_lat", 32'(r_done_cyc), 32'd5);
    check_val("to_err", 32'(r_err), 32'h1);
    check_val("to_rdata", r_rdata, 32'h0);
    check_val("to_req_cyc", 32'(r_req_cyc), 32'd4);
    check_val("to_mreq_after", 32'(r_mreq_after), 32'h0);

    // reset while waiting in RESP
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_signed = 1'b0;
    req_addr = 32'h1000; req_wdata = 32'h0;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(posedge clk); #1;
    check_val("rr_pre_stall", 32'(stall), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rr_mem_req", 32'(mem_req), 32'h0);
    check_val("rr_stall", 32'(stall), 32'h0);
    check_val("rr_rsp_valid", 32'(rsp_valid), 32'h0);
    req_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    @(posedge clk); #1;
    check_val("rr_no_rsp", 32'(extra), 32'd0);
    bus_mem[1] = 32'hCAFE_0001;
    run_access(1'b0, 2'b11, 1'b0, 32'h1004, 32'h0, 1, 1);
    check_val("rr_after_rdata", r_rdata, 32'hCAFE_0001);
    check_val("rr_after_lat", 32'(r_done_cyc), 32'd5);
    check_val("rr_after_err", 32'(r_err), 32'h0);

    // randomized mix against the byte model
    init_mem();
    for (int t = 0; t < 120; t++) begin
      we  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(1, 3));
      sgn = 1'($urandom_range(0, 1));
      a   = int'($urandom_range(0, 55));
      wd  = $urandom;
      gd  = we ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 5));
      rd  = we ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 5));
      ref_access(we, sz, sgn, a, wd, gd, rd, lat, err, rdat);
      run_access(we, sz, sgn, 32'h1000 + 32'(a), wd, gd, rd);
      check_val("rnd_lat", 32'(r_done_cyc), 32'(lat));
      check_val("rnd_err", 32'(r_err), 32'(err));
      check_val("rnd_rdata", r_rdata, rdat);
      check_val("rnd_stall", 32'(r_stall), 32'(lat));
      check_val("rnd_stable", 32'(r_stable), 32'h1);
      check_val("rnd_extra", 32'(r_extra), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/anu_lsu.md
Name: anu_lsu

Overview:
- Multi-cycle load/store unit between the anu core datapath and a handshaked data-memory bus.
- Replaces the single-cycle, half-clock mem_access_mode write path.
- Supports byte, half and word accesses with sign/zero extension, lane steering, write strobes and variable memory latency.
- Drives a stall back to the core's p_cntr so the PC holds while an access is in flight.

Parameters:
- ADDR_W, 32, bus and request address width.
- TIMEOUT, 255, max cycles waiting for mem_gnt/mem_rvalid before abort; 0 disables the timeout.
- TO_W, 8, timeout counter width; must satisfy TIMEOUT < 2**TO_W.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core presents load/store this cycle.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  01 byte, 10 half, 11 word; 00 is illegal and is treated as no request.
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address (ALU output).
- req_wdata  in  32  store data, rs2.
- stall  out  1  hold PC/instruction.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data, valid with rsp_valid.
- rsp_err  out  1  misaligned or timeout, valid with rsp_valid.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  ADDR_W  word-aligned address, bits[1:0]=0.
- mem_wstrb  out  4  byte enables.
- mem_wdata  out  32  lane-steered store data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  response; read data or write ack.
- mem_rdata  in  32  read data.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Assertion mid-access aborts immediately (mem_req drops asynchronously). No rsp_valid is produced for the aborted access.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If req_valid and req_size!=00, latch addr, we, size, signed and wdata, then go to REQ.
  - If the access is misaligned and splitting is disabled, latch err=1 and go to DONE with no bus activity.
- REQ: mem_req=1. addr, we, wstrb and wdata are held stable until mem_gnt. On mem_gnt go to RESP.
- RESP: wait for mem_rvalid, then capture mem_rdata.
  - If this is the first beat of a split access, go to REQ with addr+4.
  - Otherwise go to DONE.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. req_valid is ignored in DONE, so the held request is never re-accepted.
- stall = (IDLE & req_valid & req_size!=00) | REQ | RESP. stall is 0 in DONE so the core advances that edge.
- Zero-wait bus (gnt in the REQ cycle, rvalid on the first RESP cycle): accept at cycle 0, REQ at 1, RESP at 2, DONE/rsp_valid at 3.
- Strobes:
  - byte: 1<<addr[1:0].
  - half: 4'b0011<<(2*addr[1]).
  - word: 4'hF.
- wdata: byte replicated x4, half replicated x2, word as-is.
- Read extraction: shift right by 8*addr[1:0], mask to size, then sign- or zero-extend per req_signed.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- Timeout:
  - The counter increments each REQ/RESP cycle and clears on every accepted mem_gnt or mem_rvalid.
  - On reaching TIMEOUT (when nonzero): drop mem_req, set rsp_err=1, rsp_rdata=0, go to DONE.
- rsp_rdata is 0 for stores and on error.

Optional Feature:
- Macro ANU_LSU_MISALIGN_SPLIT_EN.
- Defined: a misaligned access issues two bus beats.
  - Beat 1: aligned word with the low-part strobes.
  - Beat 2: word+4 with the remaining strobes.
  - Read result is {beat2,beat1}>>8*offset, then extended.
  - rsp_err is 0 unless a timeout occurs.
- Undefined: a misaligned access completes in DONE with rsp_err=1 after a 1-cycle stall, and mem_req is never asserted.

Decomposition:
- Package anu_pkg holds:
  - size encodings SZ_NONE/SZ_B/SZ_H/SZ_W (2'b00..2'b11, matching the existing mem_access_mode encoding);
  - lsu state enum;
  - the strobe-generation function.
- One sub-module, anu_lsu_align: combinational lane steering of store data and strobes, plus load extraction and extension. The FSM, counter and capture registers stay in anu_lsu.

Test Plan:
- Store byte 0xA5 to 0x1003, zero-wait bus -> mem_addr 0x1000, wstrb 4'b1000, wdata 0xA5A5A5A5. stall high for cycles 0-2, rsp_valid at cycle 3, rsp_err=0.
- Load half signed from 0x2002 with mem_rdata 0x8001_1234 and 3 wait cycles before gnt -> rsp_rdata 0xFFFF8001. Request signals stay stable while gnt=0.
- Load word from 0x3001, macro undefined -> no mem_req, rsp_err=1 at cycle 1.
- Same load with macro defined, mem[0x3000]=0x44332211, mem[0x3004]=0x88776655 -> two beats, rsp_rdata 0x55443322.
- Bus never asserts gnt, TIMEOUT=4 -> rsp_valid with rsp_err=1 after 4 REQ cycles, mem_req low after.
- rst_n pulsed low during RESP -> outputs 0 immediately. After release, a new load completes normally, and no rsp_valid is produced for the aborted access.
